pov_dp_ram: RTL and testbench

//   Parametrised 1-write/1-read synchronous RAM for POV frame and line storage; successor to the basic RAM wrapper.

---
 rtl/pov_dp_ram.sv | 136 +++++++++++++
 tb/tb_pov_dp_ram.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pov_dp_ram.sv
// 1-write/1-read synchronous RAM with configurable read latency, write-first forwarding and a post-reset clear sweep.
// Optional per-word even parity, enabled by defining POV_RAM_PARITY_EN.
module pov_dp_ram #(
  parameter int unsigned           DAT_WIDTH  = 24,
  parameter int unsigned           ADDR_WIDTH = 14,
  parameter int unsigned           RD_LATENCY = 2,
  parameter logic [DAT_WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] wraddress,
  input  logic [DAT_WIDTH-1:0]  data,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic                  pinj,
  output logic [DAT_WIDTH-1:0]  q,
  output logic                  q_valid,
  output logic                  busy,
  output logic                  parity_err
);

`ifdef POV_RAM_PARITY_EN
  localparam int unsigned SW = DAT_WIDTH + 1;
`else
  localparam int unsigned SW = DAT_WIDTH;
`endif
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
  logic [SW-1:0]           mem_q [DEPTH];
  logic [SW-1:0]           data_word, init_word, wword;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic                    we, rd_acc, fwd;
  logic                    v1_q, fwd_q;
  logic [SW-1:0]           rdat_q, fwdat_q, word1, qword;

`ifdef POV_RAM_PARITY_EN
  assign data_word = {(^data) ^ pinj, data};
  assign init_word = {^INIT_VALUE, INIT_VALUE};
`else
  logic unused_pinj;
  assign unused_pinj = pinj;
  assign data_word   = data;
  assign init_word   = INIT_VALUE;
`endif

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    we      = wren;
    waddr   = wraddress;
    wword   = data_word;
    if (state_q == CLEAR) begin
      we      = 1'b1;
      waddr   = sweep_q;
      wword   = init_word;
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == '1) state_d = READY;
    end
  end

  assign busy   = (state_q == CLEAR);
  assign rd_acc = rden & ~busy;
  assign fwd    = rd_acc & wren & (wraddress == rdaddress);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wword;
  end

  // Forwarding is resolved after the array read so the array stays a plain simple dual-port RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q    <= 1'b0;
      fwd_q   <= 1'b0;
      fwdat_q <= '0;
      rdat_q  <= '0;
    end else begin
      v1_q <= rd_acc;
      if (rd_acc) begin
        fwd_q   <= fwd;
        fwdat_q <= wword;
        rdat_q  <= mem_q[rdaddress];
      end
    end
  end

  assign word1 = fwd_q ? fwdat_q : rdat_q;

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign qword   = word1;
      assign q_valid = v1_q;
    end else if (RD_LATENCY == 2) begin : g_lat2
      logic [SW-1:0] q2_q;
      logic          v2_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          q2_q <= '0;
          v2_q <= 1'b0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) q2_q <= word1;
        end
      end
      assign qword   = q2_q;
      assign q_valid = v2_q;
    end else begin : g_bad_latency
      $error("pov_dp_ram: RD_LATENCY must be 1 or 2");
      assign qword   = '0;
      assign q_valid = 1'b0;
    end
  endgenerate

  assign q = qword[DAT_WIDTH-1:0];

`ifdef POV_RAM_PARITY_EN
  assign parity_err = q_valid & (^qword);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_pov_dp_ram.sv
// Directed bench for pov_dp_ram: one latency-2 and one latency-1 instance driven by the same stimulus.
module tb_pov_dp_ram;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        wren, rden, pinj;
  logic [3:0]  wraddress, rdaddress;
  logic [23:0] data;
  logic [23:0] q2, q1;
  logic        qv2, qv1, b2, b1, pe2, pe1;
  int          passed = 0;
  int          total  = 0;
  int          n;

`ifdef POV_RAM_PARITY_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  always #5 clk = ~clk;

  pov_dp_ram #(.DAT_WIDTH(24), .ADDR_WIDTH(4), .RD_LATENCY(2), .INIT_VALUE(24'h000000)) u_l2 (
    .clk(clk), .reset_n(reset_n), .wren(wren), .wraddress(wraddress), .data(data),
    .rden(rden), .rdaddress(rdaddress), .pinj(pinj),
    .q(q2), .q_valid(qv2), .busy(b2), .parity_err(pe2));

  pov_dp_ram #(.DAT_WIDTH(24), .ADDR_WIDTH(4), .RD_LATENCY(1), .INIT_VALUE(24'h000000)) u_l1 (
    .clk(clk), .reset_n(reset_n), .wren(wren), .wraddress(wraddress), .data(data),
    .rden(rden), .rdaddress(rdaddress), .pinj(pinj),
    .q(q1), .q_valid(qv1), .busy(b1), .parity_err(pe1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then move to #1 after the next rising edge.
  task automatic cyc(input logic we, input logic [3:0] wa, input logic [23:0] d,
                     input logic re, input logic [3:0] ra, input logic pj);
    wren = we; wraddress = wa; data = d; rden = re; rdaddress = ra; pinj = pj;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    wren = 1'b0; rden = 1'b0; pinj = 1'b0;
    wraddress = '0; rdaddress = '0; data = '0;
    #1;
    chk("rst_q2", q2, 0);   chk("rst_q1", q1, 0);
    chk("rst_qv2", qv2, 0); chk("rst_qv1", qv1, 0);
    chk("rst_b2", b2, 1);   chk("rst_b1", b1, 1);
    chk("rst_pe2", pe2, 0); chk("rst_pe1", pe1, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    n = 0;
    while (b2 === 1'b1 && n < 40) begin
      chk("sweep_qv2", qv2, 0);
      n++;
      cyc(0, 0, 0, 0, 0, 0);
    end
    chk("busy_cycles", n, 16);
    chk("busy1_done", b1, 0);

    // Test 1: read back the cleared array.
    for (int k = 0; k < 18; k++) begin
      cyc(0, 0, 0, k < 16, 4'(k), 0);
      chk("t1_qv1", qv1, (k < 16) ? 1 : 0);
      chk("t1_q1", q1, 0);
      chk("t1_qv2", qv2, (k >= 1 && k <= 16) ? 1 : 0);
      chk("t1_q2", q2, 0);
      chk("t1_pe1", pe1, 0);
      chk("t1_pe2", pe2, 0);
    end

    // Test 2: write then read next cycle.
    cyc(1, 5, 24'hABCDEF, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 0);
    chk("t2_qv1", qv1, 1); chk("t2_q1", q1, 24'hABCDEF); chk("t2_qv2_early", qv2, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t2_qv2", qv2, 1); chk("t2_q2", q2, 24'hABCDEF);
    chk("t2_qv1_off", qv1, 0); chk("t2_q1_hold", q1, 24'hABCDEF);

    // Test 3: same-address read during write returns the new word.
    cyc(1, 7, 24'h123456, 1, 7, 0);
    chk("t3_qv1", qv1, 1); chk("t3_q1", q1, 24'h123456);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t3_qv2", qv2, 1); chk("t3_q2", q2, 24'h123456);

    // Test 4: back-to-back reads, in order, then hold.
    cyc(1, 0, 24'h11, 0, 0, 0);
    cyc(1, 1, 24'h22, 0, 0, 0);
    cyc(1, 2, 24'h33, 0, 0, 0);
    cyc(1, 3, 24'h44, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t4_q1_0", q1, 24'h11); chk("t4_qv1_0", qv1, 1);
    cyc(0, 0, 0, 1, 1, 0);
    chk("t4_q1_1", q1, 24'h22); chk("t4_q2_0", q2, 24'h11); chk("t4_qv2_0", qv2, 1);
    cyc(0, 0, 0, 1, 2, 0);
    chk("t4_q1_2", q1, 24'h33); chk("t4_q2_1", q2, 24'h22);
    cyc(0, 0, 0, 1, 3, 0);
    chk("t4_q1_3", q1, 24'h44); chk("t4_q2_2", q2, 24'h33); chk("t4_qv1_3", qv1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t4_qv1_off", qv1, 0); chk("t4_q1_hold", q1, 24'h44);
    chk("t4_q2_3", q2, 24'h44); chk("t4_qv2_3", qv2, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t4_qv2_off", qv2, 0); chk("t4_q2_hold", q2, 24'h44);

    // Test 6: injected parity error, stored and forwarded.
    cyc(1, 3, 24'h0000F0, 0, 0, 1);
    cyc(0, 0, 0, 1, 3, 0);
    chk("t6_q1", q1, 24'h0000F0); chk("t6_pe1", pe1, PE);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t6_pe2", pe2, PE); chk("t6_qv2", qv2, 1); chk("t6_pe1_idle", pe1, 0);
    cyc(1, 9, 24'h000001, 1, 9, 1);
    chk("t6_fwd_q1", q1, 24'h000001); chk("t6_fwd_pe1", pe1, PE);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t6_fwd_pe2", pe2, PE); chk("t6_pe1_off", pe1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t6_pe2_off", pe2, 0);

    // Test 5: reset with a read in flight, then reset mid-sweep.
    cyc(0, 0, 0, 1, 5, 0);
    reset_n = 1'b0;
    #1;
    chk("t5_qv1_flush", qv1, 0); chk("t5_qv2_flush", qv2, 0);
    chk("t5_q1_rst", q1, 0); chk("t5_q2_rst", q2, 0); chk("t5_b2_rst", b2, 1);
    rden = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) cyc(0, 0, 0, 0, 0, 0);
    chk("t5_b2_mid", b2, 1);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    n = 0;
    while (b2 === 1'b1 && n < 40) begin
      chk("t5_qv2_busy", qv2, 0);
      chk("t5_qv1_busy", qv1, 0);
      n++;
      cyc(0, 0, 0, 1, 4'(n), 0);
    end
    chk("t5_busy_cycles", n, 16);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t5_qv1_none", qv1, 0); chk("t5_qv2_none", qv2, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t5_qv2_none2", qv2, 0);
    cyc(0, 0, 0, 1, 5, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t5_recleared_qv2", qv2, 1); chk("t5_recleared_q2", q2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
